// File: rtl/vga_cursor_overlay.sv
// vga_cursor_overlay: rebuilds beam position from the sync pulses and
// composites a 16x16 2-bpp cursor, one registered cycle behind the input.
module vga_cursor_overlay #(
  parameter int H_LINE          = 640,
  parameter int H_BACK_PORCH    = 48,
  parameter int V_LINE          = 480,
  parameter int V_BACK_PORCH    = 33,
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int CURSOR_SIZE     = 16
) (
  input  logic        pxclk,
  input  logic        rst_n,
  input  logic [3:0]  r_in,
  input  logic [3:0]  g_in,
  input  logic [3:0]  b_in,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic        cfg_we,
  input  logic [4:0]  cfg_addr,
  input  logic [31:0] cfg_wdata,
  output logic [3:0]  r,
  output logic [3:0]  g,
  output logic [3:0]  b,
  output logic        hsync,
  output logic        vsync,
  output logic        frame_locked
);

  localparam logic        LOW = SYNC_ACTIVE_LOW;
  localparam logic [11:0] HBP = 12'(H_BACK_PORCH);
  localparam logic [11:0] HLN = 12'(H_LINE);
  localparam logic [11:0] VBP = 12'(V_BACK_PORCH);
  localparam logic [11:0] VLN = 12'(V_LINE);
  localparam logic [11:0] CSZ = 12'(CURSOR_SIZE);

  logic        r_hs_d;
  logic        r_vs_d;
  logic [10:0] r_col;
  logic [10:0] r_row;
  logic        r_lock;
  logic        r_en;
  logic [31:0] r_bmp [16];
  logic [11:0] r_c0;
  logic [11:0] r_c1;
  logic [10:0] r_sx;
  logic [10:0] r_sy;
  logic [10:0] r_cx;
  logic [10:0] r_cy;
  logic [11:0] r_rgb;
  logic        r_hso;
  logic        r_vso;

  logic        w_hs;
  logic        w_vs;
  logic        w_hte;
  logic        w_vte;
  logic [10:0] w_col;
  logic [10:0] w_row;
  logic [11:0] w_x;
  logic [11:0] w_y;
  logic        w_vis;
  logic        w_hit;
  logic [3:0]  w_dx;
  logic [3:0]  w_dy;
  logic [31:0] w_line;
  logic [1:0]  w_code;
  logic [11:0] w_in;
  logic [11:0] w_rgb;

  assign w_hs  = hsync_in ^ LOW;
  assign w_vs  = vsync_in ^ LOW;
  assign w_hte = r_hs_d & ~w_hs;
  assign w_vte = r_vs_d & ~w_vs;

  // Counters describe the pixel on the inputs this cycle.
  always_comb begin
    w_col = r_col;
    if (w_hte)
      w_col = '0;
    else if (r_col != 11'h7FF)
      w_col = r_col + 11'd1;
  end

  always_comb begin
    w_row = r_row;
    if (w_vte)
      w_row = '0;
    else if (w_hte && r_row != 11'h7FF)
      w_row = r_row + 11'd1;
  end

  assign w_x = {1'b0, w_col} - HBP;
  assign w_y = {1'b0, w_row} - VBP;

  assign w_vis = ({1'b0, w_col} >= HBP) && (w_x < HLN) &&
                 ({1'b0, w_row} >= VBP) && (w_y < VLN);

  assign w_hit = r_en && r_lock && w_vis &&
                 (w_x >= {1'b0, r_cx}) &&
                 (w_x < {1'b0, r_cx} + CSZ) &&
                 (w_y >= {1'b0, r_cy}) &&
                 (w_y < {1'b0, r_cy} + CSZ);

  assign w_dx   = w_x[3:0] - r_cx[3:0];
  assign w_dy   = w_y[3:0] - r_cy[3:0];
  assign w_line = r_bmp[w_dy];
  assign w_code = w_hit ? w_line[{w_dx, 1'b0} +: 2] : 2'd0;
  assign w_in   = {r_in, g_in, b_in};

  always_comb begin
    w_rgb = w_in;
    unique case (w_code)
      2'd1:    w_rgb = r_c0;
      2'd2:    w_rgb = r_c1;
      2'd3:    w_rgb = ~w_in;
      default: w_rgb = w_in;
    endcase
  end

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      r_hs_d <= 1'b0;
      r_vs_d <= 1'b0;
      r_col  <= '0;
      r_row  <= '0;
      r_lock <= 1'b0;
      r_cx   <= '0;
      r_cy   <= '0;
    end else begin
      r_hs_d <= w_hs;
      r_vs_d <= w_vs;
      r_col  <= w_col;
      r_row  <= w_row;
      if (w_vte) begin
        r_lock <= 1'b1;
        r_cx   <= r_sx;
        r_cy   <= r_sy;
      end
    end
  end

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      for (int i = 0; i < 16; i++)
        r_bmp[i] <= '0;
      r_c0 <= '0;
      r_c1 <= '0;
      r_sx <= '0;
      r_sy <= '0;
      r_en <= 1'b0;
    end else if (cfg_we) begin
      unique case (1'b1)
        !cfg_addr[4]: r_bmp[cfg_addr[3:0]] <= cfg_wdata;
        cfg_addr == 5'd16: begin
          r_sx <= cfg_wdata[10:0];
          r_sy <= cfg_wdata[26:16];
        end
        cfg_addr == 5'd17: begin
          r_c0 <= cfg_wdata[11:0];
          r_c1 <= cfg_wdata[27:16];
        end
        cfg_addr == 5'd18: r_en <= cfg_wdata[0];
        default: ;
      endcase
    end
  end

  always_ff @(posedge pxclk) begin
    if (!rst_n) begin
      r_rgb <= '0;
      r_hso <= LOW;
      r_vso <= LOW;
    end else begin
      r_rgb <= w_rgb;
      r_hso <= hsync_in;
      r_vso <= vsync_in;
    end
  end

  assign r            = r_rgb[11:8];
  assign g            = r_rgb[7:4];
  assign b            = r_rgb[3:0];
  assign hsync        = r_hso;
  assign vsync        = r_vso;
  assign frame_locked = r_lock;

endmodule

// File: doc/vga_cursor_overlay.md
Name: vga_cursor_overlay

Overview:
- Post-processing stage placed directly downstream of the VGA frame-buffer output; consumes its 4-bit r/g/b and hsync/vsync.
- Reconstructs the beam position from the sync pulses and overlays a 16x16 2-bpp hardware cursor.
- Drives the pins with one cycle of latency, keeping sync and colour aligned.
- Cursor bitmap, position, colours and enable are written through a simple write-only register port in the pxclk domain.

Parameters:
- H_LINE, 640, visible pixels per line
- H_BACK_PORCH, 48, pxclk cycles from the hsync trailing edge to pixel x=0
- V_LINE, 480, visible lines per frame
- V_BACK_PORCH, 33, lines from the vsync trailing edge to line y=0
- SYNC_ACTIVE_LOW, 1, 1 means the syncs are asserted low (inputs and outputs)
- CURSOR_SIZE, 16, cursor edge in pixels; fixed at 16 and not otherwise supported

Ports:
- pxclk  in  1  pixel clock
- rst_n  in  1  reset, synchronous, active-low
- r_in  in  4  upstream red
- g_in  in  4  upstream green
- b_in  in  4  upstream blue
- hsync_in  in  1  upstream hsync, aligned with r/g/b_in
- vsync_in  in  1  upstream vsync, aligned with r/g/b_in
- cfg_we  in  1  register write strobe, one write per cycle
- cfg_addr  in  5  register index
- cfg_wdata  in  32  write data
- r  out  4  red to pins
- g  out  4  green to pins
- b  out  4  blue to pins
- hsync  out  1  hsync to pins
- vsync  out  1  vsync to pins
- frame_locked  out  1  position tracking valid

Behaviour:
- Reset values:
  - r, g, b = 0.
  - hsync and vsync are held at the inactive level (1 if SYNC_ACTIVE_LOW, else 0).
  - frame_locked = 0.
  - All registers and counters = 0.
- Sync edges: input syncs are normalised to active-high internally. A trailing edge is the first cycle the sync is inactive after at least one active cycle.
- Column counter col (11 bits):
  - Loaded with 0 on the hsync trailing-edge cycle; increments every cycle otherwise, saturating at 2047.
  - x = col - H_BACK_PORCH; the pixel is visible horizontally while 0 <= x < H_LINE.
- Row counter row (11 bits):
  - Loaded with 0 on the vsync trailing edge; increments on every hsync trailing edge, saturating.
  - y = row - V_BACK_PORCH; the pixel is visible vertically while 0 <= y < V_LINE.
  - If both trailing edges fall in the same cycle, row = 0.
- frame_locked sets on the first vsync trailing edge after reset and stays set until the next reset. While it is 0, the block is pure pass-through (delayed by one cycle).
- Registers, all write-only:
  - 0..15: bitmap row n; pixel i (0 = leftmost) is bits [2i+1:2i].
  - 16: position shadow; x = wdata[10:0], y = wdata[26:16].
  - 17: colours; c0 = wdata[11:0], c1 = wdata[27:16], each {r,g,b} 4 bits.
  - 18: control; bit0 = enable.
  - 19..31: writes ignored.
- Write timing: bitmap, colour and control writes take effect the cycle after the strobe.
- Position commit:
  - The active position (cx, cy) is loaded from the shadow on each vsync trailing edge, so the cursor never tears mid-frame.
  - A register-16 write in that same cycle updates the shadow; the commit uses the prior shadow value.
- Cursor hit condition: enable=1, frame_locked=1, the pixel is visible, cx <= x < cx+16 and cy <= y < cy+16.
  - Compare with 12-bit arithmetic so that cx+16 does not wrap.
  - A cursor partially or fully off-screen is clipped naturally.
- Pixel code p = bitmap[y-cy][2(x-cx)+1 : 2(x-cx)] on a hit, else 0:
  - 0: pass through r/g/b_in.
  - 1: output c0.
  - 2: output c1.
  - 3: output the bitwise inverse of r/g/b_in.
- Latency: every output is registered, with exactly 1 cycle from input to output for colour and sync alike. Outside visible area, colour passes through unchanged; the block never forces blanking.
- Reset mid-frame: on the next cycle outputs return to reset values and tracking restarts unlocked.

Test Plan:
- Reset, then drive 640x480 timing with a constant input colour 0x5A3 and enable=0 -> outputs equal the inputs delayed 1 cycle; frame_locked rises the cycle after the first vsync trailing edge.
- Write bitmap row 0 = 0x0000_0001, colours c0=0xF00, position (10,20), enable=1, then wait one frame -> only pixel (10,20) outputs r=F,g=0,b=0; pixel (11,20) passes through.
- Fill a bitmap row with all code 3 and input 0x123 -> the 16 pixels on that row output 0xEDC.
- Position (632,472) with a full bitmap of code 2 -> an 8x8 block in the bottom-right corner shows c1; no effect on the next line or frame start, and no wrap.
- Write position (100,100) in the same cycle as a vsync trailing edge -> the cursor moves only at the following frame.
- Assert rst_n low mid-line -> syncs go inactive, colour 0, frame_locked=0; no cursor pixels until a vsync trailing edge occurs and enable is written again.
